motor_drive_mc: RTL and testbench

MOTOR_DRIVE_MC -- requirements
Module: motor_drive_mc

---
 rtl/motor_drive_mc_pkg.sv | 24 ++
 rtl/motor_channel.sv | 199 +++++++++++++++++++
 rtl/motor_drive_mc.sv | 76 +++++++
 tb/tb_motor_drive_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_drive_mc_pkg.sv
// Shared motor-drive definitions: direction codes, channel FSM states and
// default parameter values used by the top level and every channel.
package motor_drive_mc_pkg;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_POS  = 2'b10;
   localparam logic [1:0] DIR_NEG  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_RUN       = 2'b01,
      ST_RAMP_DOWN = 2'b10,
      ST_DEAD      = 2'b11
   } motor_state_e;

   localparam int DEF_NCH          = 2;
   localparam int DEF_PWR_W        = 16;
   localparam int DEF_DUTY_W       = 10;
   localparam int DEF_PERIOD       = 2000;
   localparam int DEF_OFFSET       = 400;
   localparam int DEF_RAMP_STEP    = 64;
   localparam int DEF_DEAD_PERIODS = 2;

endpackage

// File: rtl/motor_channel.sv
// One motor channel: command-to-target mapping, ramp/reversal FSM and the
// registered PWM comparator. All state moves only on the shared period tick.
module motor_channel
   import motor_drive_mc_pkg::*;
#(
   parameter int PWR_W        = DEF_PWR_W,
   parameter int DUTY_W       = DEF_DUTY_W,
   parameter int PERIOD       = DEF_PERIOD,
   parameter int OFFSET       = DEF_OFFSET,
   parameter int RAMP_STEP    = DEF_RAMP_STEP,
   parameter int DEAD_PERIODS = DEF_DEAD_PERIODS,
   parameter int CNT_W        = $clog2(PERIOD)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              tick_i,
   input  logic [CNT_W-1:0]  cnt_nxt_i,
   input  logic [PWR_W-1:0]  power_i,
   output logic              pwm_o,
   output logic [1:0]        dir_o,
   output logic [DUTY_W-1:0] duty_o,
   output logic              rev_o
);

   localparam int                DC_W      = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
   localparam int                PROD_W    = CNT_W + DUTY_W;
   localparam logic [DC_W-1:0]   DEAD_LAST = DC_W'(DEAD_PERIODS - 1);
   localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
   localparam logic [DUTY_W-1:0] FULL_DUTY = '1;
   localparam logic [PWR_W:0]    FULL_WIDE = (PWR_W + 1)'(FULL_DUTY);
   localparam logic [PWR_W:0]    OFFS_WIDE = (PWR_W + 1)'(OFFSET);

   function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
      if (tgt > cur) begin
         return ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
      end else begin
         return ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
      end
   endfunction

   function automatic logic [CNT_W-1:0] duty_to_thresh(input logic [DUTY_W-1:0] d);
      return CNT_W'((PROD_W'(d) * PROD_W'(PERIOD)) >> DUTY_W);
   endfunction

   motor_state_e      state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [1:0]        dir_q, dir_d;
   logic [DC_W-1:0]   dead_q, dead_d;
   logic              rev_q, rev_d;
   logic [CNT_W-1:0]  thresh_q, thresh_d;
   logic              pwm_q, pwm_d;

   logic              neg_s;
   logic [PWR_W-1:0]  mag_s;
   logic [PWR_W:0]    sum_s;
   logic [DUTY_W-1:0] tgt_duty_s;
   logic [1:0]        tgt_dir_s;
   logic [DUTY_W-1:0] dn_s;
   logic [DUTY_W-1:0] up_s;
   logic [DUTY_W-1:0] follow_s;

   // Target duty and direction from the signed command; the sum is one bit wider so it cannot wrap.
   always_comb begin
      neg_s = power_i[PWR_W-1];
      mag_s = neg_s ? (~power_i + PWR_W'(1)) : power_i;
      sum_s = {1'b0, mag_s} + OFFS_WIDE;
      if (mag_s == '0) begin
         tgt_duty_s = '0;
         tgt_dir_s  = DIR_STOP;
      end else begin
         tgt_dir_s  = neg_s ? DIR_NEG : DIR_POS;
         tgt_duty_s = (sum_s > FULL_WIDE) ? FULL_DUTY : sum_s[DUTY_W-1:0];
      end
      dn_s     = ramp_toward(duty_q, '0);
      up_s     = ramp_toward('0, tgt_duty_s);
      follow_s = ramp_toward(duty_q, tgt_duty_s);
   end

   // Next-state, ramp and PWM threshold logic.
   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      dir_d    = dir_q;
      dead_d   = dead_q;
      rev_d    = rev_q;
      thresh_d = thresh_q;
      pwm_d    = 1'b0;
      if (!enable_i) begin
         state_d  = ST_IDLE;
         duty_d   = '0;
         dir_d    = DIR_STOP;
         dead_d   = '0;
         rev_d    = 1'b0;
         thresh_d = '0;
      end else if (tick_i) begin
         case (state_q)
            ST_IDLE: begin
               if (tgt_dir_s != DIR_STOP) begin
                  state_d = ST_RUN;
                  dir_d   = tgt_dir_s;
                  duty_d  = up_s;
               end else begin
                  duty_d  = '0;
                  dir_d   = DIR_STOP;
               end
            end
            ST_RUN: begin
               if (tgt_dir_s == dir_q) begin
                  duty_d = follow_s;
               end else if (tgt_dir_s == DIR_STOP) begin
                  duty_d = dn_s;
                  if (dn_s == '0) begin
                     state_d = ST_IDLE;
                     dir_d   = DIR_STOP;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  duty_d = dn_s;
                  rev_d  = 1'b1;
                  if (dn_s == '0) begin
                     state_d = ST_DEAD;
                     dir_d   = DIR_STOP;
                     dead_d  = '0;
                  end else begin
                     state_d = ST_RAMP_DOWN;
                  end
               end
            end
            ST_RAMP_DOWN: begin
               duty_d = dn_s;
               if (dn_s == '0) begin
                  state_d = ST_DEAD;
                  dir_d   = DIR_STOP;
                  dead_d  = '0;
               end else begin
                  state_d = ST_RAMP_DOWN;
               end
            end
            ST_DEAD: begin
               if (dead_q == DEAD_LAST) begin
                  rev_d  = 1'b0;
                  dead_d = '0;
                  if (tgt_dir_s != DIR_STOP) begin
                     state_d = ST_RUN;
                     dir_d   = tgt_dir_s;
                     duty_d  = up_s;
                  end else begin
                     state_d = ST_IDLE;
                     dir_d   = DIR_STOP;
                  end
               end else begin
                  dead_d = dead_q + DC_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               duty_d  = '0;
               dir_d   = DIR_STOP;
               dead_d  = '0;
               rev_d   = 1'b0;
            end
         endcase
         thresh_d = duty_to_thresh(duty_d);
      end else begin
         thresh_d = thresh_q;
      end
      pwm_d = (dir_d != DIR_STOP) && (cnt_nxt_i < thresh_d);
   end

   // Channel state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         dir_q    <= DIR_STOP;
         dead_q   <= '0;
         rev_q    <= 1'b0;
         thresh_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         dir_q    <= dir_d;
         dead_q   <= dead_d;
         rev_q    <= rev_d;
         thresh_q <= thresh_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o  = pwm_q;
   assign dir_o  = dir_q;
   assign duty_o = duty_q;
   assign rev_o  = rev_q;

endmodule

// File: rtl/motor_drive_mc.sv
// Multi-channel motor driver: shared PWM period counter and tick, plus one
// independent motor_channel per output.
module motor_drive_mc
   import motor_drive_mc_pkg::*;
#(
   parameter int NCH          = DEF_NCH,
   parameter int PWR_W        = DEF_PWR_W,
   parameter int DUTY_W       = DEF_DUTY_W,
   parameter int PERIOD       = DEF_PERIOD,
   parameter int OFFSET       = DEF_OFFSET,
   parameter int RAMP_STEP    = DEF_RAMP_STEP,
   parameter int DEAD_PERIODS = DEF_DEAD_PERIODS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NCH*PWR_W-1:0]    power,
   output logic [NCH-1:0]          pwm,
   output logic [2*NCH-1:0]        direction,
   output logic [NCH*DUTY_W-1:0]   duty,
   output logic [NCH-1:0]          reversing,
   output logic                    tick
);

   localparam int               CNT_W    = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q;

   // Counter wraps at the end of the period; it keeps running while enable is low.
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Period counter and registered tick, high exactly while the counter sits at its last value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_d == CNT_LAST);
      end
   end

   assign tick = tick_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      motor_channel #(
         .PWR_W        (PWR_W),
         .DUTY_W       (DUTY_W),
         .PERIOD       (PERIOD),
         .OFFSET       (OFFSET),
         .RAMP_STEP    (RAMP_STEP),
         .DEAD_PERIODS (DEAD_PERIODS),
         .CNT_W        (CNT_W)
      ) u_ch (
         .clk_i     (clk),
         .rst_i     (reset),
         .enable_i  (enable),
         .tick_i    (tick_q),
         .cnt_nxt_i (cnt_d),
         .power_i   (power[g*PWR_W +: PWR_W]),
         .pwm_o     (pwm[g]),
         .dir_o     (direction[2*g +: 2]),
         .duty_o    (duty[g*DUTY_W +: DUTY_W]),
         .rev_o     (reversing[g])
      );
   end

endmodule

// File: tb/tb_motor_drive_mc.sv
// Scoreboard bench for motor_drive_mc with default parameters: directed
// commands per period, expected channel state checked after every tick.
module tb_motor_drive_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] power;
   logic [1:0]  pwm;
   logic [3:0]  direction;
   logic [19:0] duty;
   logic [1:0]  reversing;
   logic        tick;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         d0;
      logic [1:0] dir0;
      bit         rev0;
      int         d1;
      logic [1:0] dir1;
      bit         rev1;
      bit         chk_pwm;
      int         hi0;
      int         hi1;
   } exp_t;

   exp_t sb_q[$];

   int ph1_d0 [19] = '{64, 128, 192, 256, 320, 384, 448, 500,
                       436, 372, 308, 244, 180, 116, 52, 0, 0, 64, 128};

   motor_drive_mc dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .power     (power),
      .pwm       (pwm),
      .direction (direction),
      .duty      (duty),
      .reversing (reversing),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick !== 1'b1 && n < 2100);
      if (tick !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL tick_timeout: got no tick after %0d cycles, expected one within 2000", n);
      end
   endtask

   task automatic issue(input logic [15:0] p0, input logic [15:0] p1,
                        input int d0, input logic [1:0] dir0, input bit rev0,
                        input int d1, input logic [1:0] dir1, input bit rev1,
                        input bit cp, input int h0, input int h1);
      exp_t e;
      power     = {p1, p0};
      e.d0      = d0;
      e.dir0    = dir0;
      e.rev0    = rev0;
      e.d1      = d1;
      e.dir1    = dir1;
      e.rev1    = rev1;
      e.chk_pwm = cp;
      e.hi0     = h0;
      e.hi1     = h1;
      sb_q.push_back(e);
   endtask

   // Monitor: after each tick pop the expected state; count pwm high cycles over the following period.
   initial begin : monitor
      exp_t cur;
      bit   active;
      bit   prev_tick;
      int   hi0;
      int   hi1;
      int   idx;
      active    = 1'b0;
      prev_tick = 1'b0;
      hi0       = 0;
      hi1       = 0;
      idx       = 0;
      forever begin
         @(negedge clk);
         if (prev_tick && sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            idx++;
            chk($sformatf("e%0d_ch0_duty", idx), int'(duty[9:0]), cur.d0);
            chk($sformatf("e%0d_ch0_dir", idx), int'(direction[1:0]), int'(cur.dir0));
            chk($sformatf("e%0d_ch0_rev", idx), int'(reversing[0]), int'(cur.rev0));
            chk($sformatf("e%0d_ch1_duty", idx), int'(duty[19:10]), cur.d1);
            chk($sformatf("e%0d_ch1_dir", idx), int'(direction[3:2]), int'(cur.dir1));
            chk($sformatf("e%0d_ch1_rev", idx), int'(reversing[1]), int'(cur.rev1));
            active = 1'b1;
            hi0    = 0;
            hi1    = 0;
         end
         if (active) begin
            hi0 += int'(pwm[0]);
            hi1 += int'(pwm[1]);
         end
         if (active && tick === 1'b1) begin
            if (cur.chk_pwm) begin
               chk($sformatf("e%0d_ch0_pwm_high", idx), hi0, cur.hi0);
               chk($sformatf("e%0d_ch1_pwm_high", idx), hi1, cur.hi1);
            end
            active = 1'b0;
         end
         prev_tick = (tick === 1'b1);
      end
   end

   initial begin : stimulus
      int         n;
      logic [1:0] dir0;
      bit         cp;
      reset  = 1'b1;
      enable = 1'b1;
      power  = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_dir", int'(direction), 0);
      chk("rst_duty", int'(duty), 0);
      chk("rst_rev", int'(reversing), 0);
      chk("rst_tick", int'(tick), 0);

      // Start a ramp, then hit it with an asynchronous reset at cycle 3000.
      power = {16'd1000, 16'd100};
      reset = 1'b0;
      wait_tick(n);
      chk("first_tick_cycles", n, 1999);
      issue(16'd100, 16'd1000, 64, 2'b10, 1'b0, 64, 2'b10, 1'b0, 1'b0, 0, 0);
      repeat (1001) @(negedge clk);
      chk("pre_reset_ch0_duty", int'(duty[9:0]), 64);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_pwm", int'(pwm), 0);
      chk("async_rst_dir", int'(direction), 0);
      chk("async_rst_duty", int'(duty), 0);
      chk("async_rst_rev", int'(reversing), 0);
      chk("async_rst_tick", int'(tick), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_tick(n);
      chk("tick_after_reset_cycles", n, 1999);

      // ch0: +100 up to 500, then -100 reversal; ch1: +1000 saturating at 1023.
      for (int k = 1; k <= 19; k++) begin
         if (k > 1) wait_tick(n);
         dir0 = (k <= 15) ? 2'b10 : ((k <= 17) ? 2'b00 : 2'b01);
         cp   = (k == 8) || (k == 16) || (k == 18);
         issue((k <= 8) ? 16'd100 : 16'hFF9C, 16'd1000,
               ph1_d0[k-1], dir0, (k >= 9 && k <= 17),
               (k < 16) ? 64 * k : 1023, 2'b10, 1'b0,
               cp, (k == 8) ? 976 : ((k == 16) ? 0 : 125),
               (k == 8) ? 1000 : 1998);
      end

      // Drop enable mid-period with both channels running.
      repeat (1000) @(negedge clk);
      chk("pre_drop_ch1_pwm", int'(pwm[1]), 1);
      enable = 1'b0;
      @(negedge clk);
      chk("drop_pwm", int'(pwm), 0);
      chk("drop_dir", int'(direction), 0);
      chk("drop_duty", int'(duty), 0);
      chk("drop_rev", int'(reversing), 0);
      repeat (10) @(negedge clk);
      enable = 1'b1;

      // Re-ramp from IDLE: ch0 -100, ch1 most negative code.
      for (int k = 1; k <= 16; k++) begin
         wait_tick(n);
         issue(16'hFF9C, 16'h8000,
               (k < 8) ? 64 * k : 500, 2'b01, 1'b0,
               (k < 16) ? 64 * k : 1023, 2'b01, 1'b0,
               (k == 8) || (k == 16), 976, (k == 8) ? 1000 : 1998);
      end
      wait_tick(n);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
